// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the FIFO word packer slice.
// Entry width, pack factor and lane-count width.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK       = 4;
  localparam int DEF_CNT_W      = $clog2(DEF_PACK + 1);

  function automatic int cnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/pack_out_reg.sv
// pack_out_reg: output holding register for packed words.
// Holds data/keep under backpressure, reloads on the accepting cycle.
module pack_out_reg
  import fifo_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH * DEF_PACK,
  parameter int K = DEF_PACK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic [K-1:0] keep_i,
  input  logic         ready_i,
  output logic         free_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [K-1:0] keep_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [K-1:0] keep_q, keep_d;

  // next word: load wins, else drop valid once accepted
  always_comb begin
    free_o  = !valid_q || ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      keep_d  = keep_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // output register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops FIFO entries and packs PACK of them per word.
// Flush pushes out a partial word with a lane keep mask.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK       = DEF_PACK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_rdata,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep
);

  localparam int CW = cnt_width(PACK);
  localparam int OW = DATA_WIDTH * PACK;
  localparam logic [CW-1:0] FULL = CW'(PACK);

  logic [CW-1:0]         cnt_q, cnt_d, cnt_land;
  logic                  pend_q, pend_d;
  logic                  freq_q, freq_d;
  logic [DATA_WIDTH-1:0] acc_q [PACK];
  logic [DATA_WIDTH-1:0] acc_d [PACK];
  logic [CW:0]           inflight;
  logic                  flush_act, resolve;
  logic                  emit_full, emit_part, load;
  logic                  out_free;
  logic [OW-1:0]         word;
  logic [PACK-1:0]       keep;

  // read issue: stop when accumulator plus in-flight entry is full
  always_comb begin
    inflight   = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
    fifo_rd_en = !rst && !fifo_empty && !freq_q
              && (inflight < {1'b0, FULL});
  end

  // landing, word completion and flush resolution
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < PACK; i++) begin
      if (pend_q && cnt_q == CW'(i)) acc_d[i] = fifo_rdata;
    end
    cnt_land  = cnt_q + CW'(pend_q);
    flush_act = flush || freq_q;
    resolve   = flush_act && !pend_q;
    emit_full = (cnt_land == FULL) && out_free;
    emit_part = resolve && (cnt_q != '0)
             && (cnt_q != FULL) && out_free;
    load      = emit_full || emit_part;
    keep      = '0;
    word      = '0;
    for (int i = 0; i < PACK; i++) begin
      keep[i] = emit_full || (CW'(i) < cnt_q);
      if (keep[i]) word[i*DATA_WIDTH +: DATA_WIDTH] = acc_d[i];
    end
    cnt_d  = load ? '0 : cnt_land;
    pend_d = fifo_rd_en;
    freq_d = freq_q || flush;
    if (resolve && (cnt_q == '0 || out_free)) freq_d = 1'b0;
  end

  // accumulator state, cleared by reset mid-word
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      freq_q <= 1'b0;
      for (int i = 0; i < PACK; i++) acc_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      freq_q <= freq_d;
      for (int i = 0; i < PACK; i++) acc_q[i] <= acc_d[i];
    end
  end

  pack_out_reg #(
    .W (OW),
    .K (PACK)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (word),
    .keep_i  (keep),
    .ready_i (out_ready),
    .free_o  (out_free),
    .valid_o (out_valid),
    .data_o  (out_data),
    .keep_o  (out_keep)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed and random checks of the word packer.
// FIFO is a queue model; expected words come from pushed data order.
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int OW = DW * PK;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [PK-1:0] out_keep;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]    fq[$];
  logic             push_v = 1'b0;
  logic [DW-1:0]    push_d = '0;
  int               pops = 0;
  logic [OW+PK-1:0] got[$];

  int            cyc = 0;
  int            rd_total = 0;
  int            t4 = -1;
  int            tv = -1;
  int            rd_empty_err = 0;
  int            hold_err = 0;
  logic          hold_prev = 1'b0;
  logic [OW-1:0] hd = '0;
  logic [PK-1:0] hk = '0;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .DATA_WIDTH (DW),
    .PACK       (PK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep)
  );

  // FIFO model with one-cycle registered read
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_rdata <= fq.pop_front();
      pops++;
    end
    if (push_v) fq.push_back(push_d);
    fifo_empty <= (fq.size() == 0);
  end

  // monitor: handshakes, latency marks, protocol checks
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_total++;
      if (rd_total == 4) t4 = cyc;
      if (fifo_empty) rd_empty_err++;
    end
    if (out_valid && tv < 0) tv = cyc;
    if (out_valid && out_ready) got.push_back({out_keep, out_data});
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev &&
          !(out_valid && out_data === hd && out_keep === hk))
        hold_err++;
      hold_prev = out_valid && !out_ready;
      hd = out_data;
      hk = out_keep;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    push_v = 1'b1;
    push_d = v;
    step();
    push_v = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget,
                            input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 64'(got.size() >= n), 64'(1));
  endtask

  task automatic chk_word(input string tag,
                          input logic [OW-1:0] d,
                          input logic [PK-1:0] kp);
    logic [OW+PK-1:0] w;
    if (got.size() > 0) w = got.pop_front();
    else w = 'x;
    chk(tag, 64'(w), 64'({kp, d}));
  endtask

  initial begin
    logic [OW-1:0] exp_w[$];
    logic [OW-1:0] acc;
    logic [DW-1:0] v;
    int p0;

    // reset state, preload under reset
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_keep", 64'(out_keep), 64'(0));
    for (int i = 1; i <= 8; i++) push(DW'(i));
    step();
    chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));

    // two full words, ready held high
    out_ready = 1'b1;
    rst = 1'b0;
    wait_words(2, 40, "t1_wait");
    chk_word("t1_w0", 32'h04030201, 4'hF);
    chk_word("t1_w1", 32'h08070605, 4'hF);
    chk("t1_latency", 64'(tv), 64'(t4 + 2));

    // backpressure: 12 entries, output blocked
    got.delete();
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 12; i++) push(DW'(8'h11 + i));
    for (int i = 0; i < 20; i++) step();
    chk("t2_valid", 64'(out_valid), 64'(1));
    chk("t2_data", 64'(out_data), 64'(32'h14131211));
    chk("t2_keep", 64'(out_keep), 64'(4'hF));
    chk("t2_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("t2_fifo_left", 64'(fq.size()), 64'(4));
    chk("t2_pops", 64'(pops - p0), 64'(8));
    out_ready = 1'b1;
    wait_words(3, 60, "t2_wait");
    chk_word("t2_w0", 32'h14131211, 4'hF);
    chk_word("t2_w1", 32'h18171615, 4'hF);
    chk_word("t2_w2", 32'h1C1B1A19, 4'hF);

    // flush with three landed entries
    got.delete();
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    for (int i = 0; i < 5; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_flush_lat", 64'(out_valid), 64'(1));
    wait_words(1, 10, "t3_wait");
    chk_word("t3_part", 32'h00CCBBAA, 4'b0111);
    for (int i = 0; i < 4; i++) push(DW'(8'h31 + i));
    wait_words(1, 20, "t3_wait2");
    chk_word("t3_next", 32'h34333231, 4'hF);

    // flush while a read is still in flight
    got.delete();
    push(8'hAA);
    for (int i = 0; i < 4; i++) step();
    push(8'hDD);
    chk("t4_rd_dd", 64'(fifo_rd_en), 64'(1));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_words(1, 10, "t4_wait");
    chk_word("t4_part", 32'h0000DDAA, 4'b0011);

    // sparse producer, random backpressure
    got.delete();
    for (int i = 0; i < 24; i++) begin
      v = DW'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      push(v);
      acc = {v, acc[OW-1:DW]};
      if (i % PK == PK - 1) exp_w.push_back(acc);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    wait_words(6, 100, "t5_wait");
    for (int i = 0; i < 6; i++) begin
      chk_word($sformatf("t5_w%0d", i), exp_w[i], 4'hF);
    end
    chk("rd_when_empty", 64'(rd_empty_err), 64'(0));
    chk("hold_stable", 64'(hold_err), 64'(0));

    // reset mid-word with a held output
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(8'h51 + i));
    for (int i = 0; i < 6; i++) step();
    push(8'h55);
    push(8'h56);
    for (int i = 0; i < 4; i++) step();
    chk("t6_pre_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    step();
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_data", 64'(out_data), 64'(0));
    chk("t6_keep", 64'(out_keep), 64'(0));
    chk("t6_rd_en", 64'(fifo_rd_en), 64'(0));
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(8'h41 + i));
    wait_words(1, 20, "t6_wait");
    chk_word("t6_after", 32'h44434241, 4'hF);
    chk("hold_stable_end", 64'(hold_err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
